// File: rtl/spi_flash_reader_pkg.sv
// Shared definitions for the SPI flash read controller: widths, the READ opcode,
// FSM state encoding and an address byte selector.
package spi_flash_reader_pkg;

    localparam int ADDR_W = 24;
    localparam int LEN_W  = 16;

    localparam logic [7:0] READ_CMD = 8'h03;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_STALL = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    // Byte idx of the address in transmit order (0 = most significant).
    function automatic logic [7:0] addr_byte(input logic [ADDR_W-1:0] addr, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = addr[23:16];
            2'd1:    b = addr[15:8];
            2'd2:    b = addr[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_flash_reader_shift.sv
// SCK divider plus 8-bit shift register (mode 0, MSB first). start begins a byte
// when idle, and when held during byte_end chains the next byte without an SCK gap.
module spi_shift_engine #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sck,
    output logic       mosi,
    output logic       rx_done,
    output logic       byte_end,
    output logic [7:0] rx_word,
    output logic [7:0] rx_hold
);

    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

    logic       active_r;
    logic       sck_r;
    logic       mosi_r;
    logic [7:0] div_r;
    logic [2:0] bit_r;
    logic [7:0] sr_r;
    logic       phase_end_s;

    assign phase_end_s = active_r && (div_r == 8'd0);
    assign rx_done     = phase_end_s && !sck_r && (bit_r == 3'd7);
    assign byte_end    = phase_end_s && sck_r && (bit_r == 3'd7);
    // Completed byte as it is sampled, and as it rests in the register afterwards.
    assign rx_word     = {sr_r[6:0], miso};
    assign rx_hold     = sr_r;
    assign sck         = sck_r;
    assign mosi        = mosi_r;

    // Phase timing, MISO capture on the rising phase, MOSI update on the falling phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_r <= 1'b0;
            sck_r    <= 1'b0;
            mosi_r   <= 1'b0;
            div_r    <= 8'd0;
            bit_r    <= 3'd0;
            sr_r     <= 8'h00;
        end else if (!active_r) begin
            if (start) begin
                active_r <= 1'b1;
                sr_r     <= tx_byte;
                mosi_r   <= tx_byte[7];
                div_r    <= DIV_LOAD;
                bit_r    <= 3'd0;
            end
        end else if (div_r != 8'd0) begin
            div_r <= div_r - 8'd1;
        end else begin
            div_r <= DIV_LOAD;
            if (!sck_r) begin
                sck_r <= 1'b1;
                sr_r  <= {sr_r[6:0], miso};
            end else begin
                sck_r <= 1'b0;
                if (bit_r != 3'd7) begin
                    bit_r  <= bit_r + 3'd1;
                    mosi_r <= sr_r[7];
                end else if (start) begin
                    bit_r  <= 3'd0;
                    sr_r   <= tx_byte;
                    mosi_r <= tx_byte[7];
                end else begin
                    active_r <= 1'b0;
                    mosi_r   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/spi_flash_reader.sv
// SPI flash READ (0x03) controller: sequences command, address and data bytes
// through the shift engine and hands bytes out on a valid/ready port.
module spi_flash_reader
    import spi_flash_reader_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    output logic [7:0]        data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              busy,
    output logic              spi_cs_n,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam logic [15:0] GAP_LOAD = 16'(CS_GAP - 1);

    logic [2:0]        state_r, state_n;
    logic [ADDR_W-1:0] addr_r, addr_n;
    logic [LEN_W-1:0]  cnt_r, cnt_n;
    logic [1:0]        idx_r, idx_n;
    logic [15:0]       gap_r, gap_n;
    logic              pend_r, pend_n;
    logic [7:0]        data_out_r, dout_n;
    logic              data_valid_r, dv_n;
    logic              req_ready_r;
    logic              busy_r;
    logic              cs_n_r;

    logic              accept_s;
    logic              consume_s;
    logic              slot_free_s;
    logic              load_pend_s;
    logic              eng_start_s;
    logic [7:0]        eng_tx_s;
    logic              eng_rx_done_s;
    logic              eng_byte_end_s;
    logic [7:0]        eng_rx_word_s;
    logic [7:0]        eng_rx_hold_s;

    spi_shift_engine #(.CLK_DIV(CLK_DIV)) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (eng_start_s),
        .tx_byte  (eng_tx_s),
        .miso     (spi_miso),
        .sck      (spi_sck),
        .mosi     (spi_mosi),
        .rx_done  (eng_rx_done_s),
        .byte_end (eng_byte_end_s),
        .rx_word  (eng_rx_word_s),
        .rx_hold  (eng_rx_hold_s)
    );

    assign accept_s    = req_valid && req_ready_r;
    assign consume_s   = data_valid_r && data_ready;
    assign slot_free_s = !data_valid_r || data_ready;
    // A byte parked in the shift register moves out as soon as the output slot frees.
    assign load_pend_s = pend_r && slot_free_s;

    // Next-state, output-buffer and engine-control decode.
    always_comb begin
        state_n     = state_r;
        addr_n      = addr_r;
        cnt_n       = cnt_r;
        idx_n       = idx_r;
        gap_n       = gap_r;
        pend_n      = pend_r;
        dout_n      = data_out_r;
        dv_n        = data_valid_r && !consume_s;
        eng_start_s = 1'b0;
        eng_tx_s    = 8'h00;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (req_len != 16'd0)) begin
                    state_n     = ST_CMD;
                    addr_n      = req_addr;
                    cnt_n       = req_len;
                    idx_n       = 2'd0;
                    eng_start_s = 1'b1;
                    eng_tx_s    = READ_CMD;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (eng_byte_end_s) begin
                    state_n     = ST_ADDR;
                    idx_n       = 2'd0;
                    eng_start_s = 1'b1;
                    eng_tx_s    = addr_byte(addr_r, 2'd0);
                end else begin
                    state_n = ST_CMD;
                end
            end
            ST_ADDR: begin
                if (eng_byte_end_s && (idx_r == 2'd2)) begin
                    state_n     = ST_DATA;
                    idx_n       = 2'd0;
                    eng_start_s = 1'b1;
                end else if (eng_byte_end_s) begin
                    idx_n       = idx_r + 2'd1;
                    eng_start_s = 1'b1;
                    eng_tx_s    = addr_byte(addr_r, idx_r + 2'd1);
                end else begin
                    state_n = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (eng_rx_done_s) begin
                    cnt_n = cnt_r - 16'd1;
                    if (slot_free_s) begin
                        dout_n = eng_rx_word_s;
                        dv_n   = 1'b1;
                    end else begin
                        pend_n = 1'b1;
                    end
                end else if (load_pend_s) begin
                    dout_n = eng_rx_hold_s;
                    dv_n   = 1'b1;
                    pend_n = 1'b0;
                end else begin
                    cnt_n = cnt_r;
                end
                // Continue only if the engine's register is free for the next byte.
                if (eng_byte_end_s) begin
                    if (pend_n) begin
                        state_n = ST_STALL;
                    end else if (cnt_r == 16'd0) begin
                        state_n = ST_GAP;
                        gap_n   = GAP_LOAD;
                    end else begin
                        eng_start_s = 1'b1;
                    end
                end else begin
                    state_n = ST_DATA;
                end
            end
            ST_STALL: begin
                if (load_pend_s) begin
                    dout_n = eng_rx_hold_s;
                    dv_n   = 1'b1;
                    pend_n = 1'b0;
                    if (cnt_r == 16'd0) begin
                        state_n = ST_GAP;
                        gap_n   = GAP_LOAD;
                    end else begin
                        state_n     = ST_DATA;
                        eng_start_s = 1'b1;
                    end
                end else begin
                    state_n = ST_STALL;
                end
            end
            ST_GAP: begin
                if (gap_r == 16'd0) begin
                    state_n = ST_IDLE;
                end else begin
                    gap_n = gap_r - 16'd1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered interface outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            addr_r       <= 24'h000000;
            cnt_r        <= 16'd0;
            idx_r        <= 2'd0;
            gap_r        <= 16'd0;
            pend_r       <= 1'b0;
            data_out_r   <= 8'h00;
            data_valid_r <= 1'b0;
            req_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            cs_n_r       <= 1'b1;
        end else begin
            state_r      <= state_n;
            addr_r       <= addr_n;
            cnt_r        <= cnt_n;
            idx_r        <= idx_n;
            gap_r        <= gap_n;
            pend_r       <= pend_n;
            data_out_r   <= dout_n;
            data_valid_r <= dv_n;
            req_ready_r  <= (state_n == ST_IDLE) && !dv_n;
            busy_r       <= (state_n != ST_IDLE);
            cs_n_r       <= (state_n == ST_IDLE) || (state_n == ST_GAP);
        end
    end

    assign req_ready  = req_ready_r;
    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign busy       = busy_r;
    assign spi_cs_n   = cs_n_r;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader: a CLK_DIV=2 and a CLK_DIV=1 instance share
// a behavioural READ-only flash model through a bus selector.
module tb_spi_flash_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rv0 = 1'b0, rv1 = 1'b0;
    logic [23:0] req_addr = 24'h0;
    logic [15:0] req_len = 16'h0;
    logic        data_ready = 1'b0;
    logic        miso = 1'b0;
    logic        sel = 1'b0;

    logic       rr0, dv0, busy0, cs0, sck0, mosi0;
    logic       rr1, dv1, busy1, cs1, sck1, mosi1;
    logic [7:0] do0, do1;

    always #5 clk = ~clk;

    spi_flash_reader #(.CLK_DIV(2), .CS_GAP(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv0), .req_ready(rr0), .req_addr(req_addr),
        .req_len(req_len), .data_out(do0), .data_valid(dv0), .data_ready(data_ready),
        .busy(busy0), .spi_cs_n(cs0), .spi_sck(sck0), .spi_mosi(mosi0), .spi_miso(miso)
    );

    spi_flash_reader #(.CLK_DIV(1), .CS_GAP(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_ready(rr1), .req_addr(req_addr),
        .req_len(req_len), .data_out(do1), .data_valid(dv1), .data_ready(data_ready),
        .busy(busy1), .spi_cs_n(cs1), .spi_sck(sck1), .spi_mosi(mosi1), .spi_miso(miso)
    );

    logic       bus_cs, bus_sck, bus_mosi, bus_dv, bus_rr, bus_busy;
    logic [7:0] bus_do;
    assign bus_cs   = sel ? cs1   : cs0;
    assign bus_sck  = sel ? sck1  : sck0;
    assign bus_mosi = sel ? mosi1 : mosi0;
    assign bus_dv   = sel ? dv1   : dv0;
    assign bus_rr   = sel ? rr1   : rr0;
    assign bus_busy = sel ? busy1 : busy0;
    assign bus_do   = sel ? do1   : do0;

    logic [7:0]  mem [0:31];
    logic [31:0] hdr = 32'h0;
    int bit_cnt = 0, sck_pulses = 0, cs_falls = 0, cs_run = 0, rdy_run = 0;
    int hi_run = 0, hi_min = 999, hi_max = 0, mosi_viol = 0, acc_cnt = 0;
    int acc_run [0:1];
    logic acc_dv [0:1];
    logic prev_sck = 1'b0, prev_cs = 1'b1, prev_mosi = 1'b0, prev_rr = 1'b1;
    logic [7:0] got_q [$];

    int n_vec = 0, n_err = 0;

    function automatic logic flash_bit(input logic [31:0] h, input int n);
        int d;
        logic [4:0] idx;
        logic [7:0] b;
        d   = n - 32;
        idx = h[4:0] + 5'(d / 8);
        b   = mem[idx];
        return b[7 - (d % 8)];
    endfunction

    // Flash model plus bus monitors, all sampled on the falling clk edge.
    always @(negedge clk) begin
        if (bus_cs) begin
            bit_cnt <= 0;
            miso    <= 1'b0;
        end else begin
            if (bus_sck && !prev_sck) begin
                if (bit_cnt < 32) hdr <= {hdr[30:0], bus_mosi};
                bit_cnt    <= bit_cnt + 1;
                sck_pulses <= sck_pulses + 1;
            end
            if (!bus_sck && prev_sck && bit_cnt >= 32) miso <= flash_bit(hdr, bit_cnt);
        end
        if (!bus_cs && prev_cs) cs_falls <= cs_falls + 1;
        if (bus_sck) begin
            hi_run <= hi_run + 1;
        end else if (prev_sck) begin
            if (hi_run < hi_min) hi_min <= hi_run;
            if (hi_run > hi_max) hi_max <= hi_run;
            hi_run <= 0;
        end
        if (bus_sck && prev_sck && (bus_mosi != prev_mosi)) mosi_viol <= mosi_viol + 1;
        cs_run <= bus_cs ? cs_run + 1 : 0;
        if (bus_rr && !prev_rr) rdy_run <= cs_run + 1;
        if (bus_dv && data_ready) got_q.push_back(bus_do);
        if (sel && rv1 && rr1 && acc_cnt < 2) begin
            acc_run[acc_cnt] <= bus_cs ? cs_run + 1 : 0;
            acc_dv[acc_cnt]  <= dv1;
            acc_cnt          <= acc_cnt + 1;
        end
        prev_sck  <= bus_sck;
        prev_cs   <= bus_cs;
        prev_mosi <= bus_mosi;
        prev_rr   <= bus_rr;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic at_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic which, input logic [23:0] a, input logic [15:0] l);
        at_pos();
        req_addr = a;
        req_len  = l;
        if (which) rv1 = 1'b1;
        else       rv0 = 1'b1;
        at_pos();
        rv0 = 1'b0;
        rv1 = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        do begin
            at_neg();
            n++;
        end while (!(bus_rr && !bus_busy) && n < budget);
        check_val({tag, "_done"}, 32'(bus_rr && !bus_busy), 32'd1);
    endtask

    task automatic clear_mon();
        got_q.delete();
        sck_pulses = 0;
        hi_min     = 999;
        hi_max     = 0;
        mosi_viol  = 0;
    endtask

    task automatic check_bytes(input string tag, input logic [7:0] exp [$]);
        check_val({tag, "_count"}, 32'(got_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got_q.size(); i++)
            check_val($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp[i]));
    endtask

    initial begin
        int n;
        int bad_do, bad_dv, bad_cs;
        int falls0;
        for (int i = 0; i < 32; i++) mem[i] = 8'(i * 7 + 3);
        mem[0]  = 8'h3C;
        mem[16] = 8'hA5;
        mem[17] = 8'h5A;
        mem[18] = 8'h01;
        mem[19] = 8'hFE;

        // Reset and idle
        repeat (3) at_pos();
        rst_n = 1'b1;
        repeat (20) at_pos();
        at_neg();
        check_val("rst_cs_n", 32'(cs0), 32'd1);
        check_val("rst_sck", 32'(sck0), 32'd0);
        check_val("rst_mosi", 32'(mosi0), 32'd0);
        check_val("rst_req_ready", 32'(rr0), 32'd1);
        check_val("rst_busy", 32'(busy0), 32'd0);
        check_val("rst_data_valid", 32'(dv0), 32'd0);
        check_val("rst_data_out", 32'(do0), 32'h0);

        // Four-byte read, consumer always ready
        data_ready = 1'b1;
        clear_mon();
        issue(1'b0, 24'h000010, 16'd4);
        wait_idle("rd4", 2000);
        check_bytes("rd4", '{8'hA5, 8'h5A, 8'h01, 8'hFE});
        check_val("rd4_mosi_hdr", hdr, 32'h03000010);
        check_val("rd4_sck_pulses", 32'(sck_pulses), 32'd64);
        check_val("rd4_sck_high_min", 32'(hi_min), 32'd2);
        check_val("rd4_sck_high_max", 32'(hi_max), 32'd2);
        check_val("rd4_mosi_stable", 32'(mosi_viol), 32'd0);
        check_val("rd4_cs_gap_ok", 32'(rdy_run - 1 >= 2), 32'd1);

        // Back-pressure: first byte held unconsumed for 100 clk
        data_ready = 1'b0;
        clear_mon();
        issue(1'b0, 24'h000010, 16'd4);
        n = 0;
        do begin
            at_neg();
            n++;
        end while (!bus_dv && n < 1000);
        check_val("stall_first_valid", 32'(bus_dv), 32'd1);
        bad_do = 0;
        bad_dv = 0;
        bad_cs = 0;
        for (int i = 0; i < 100; i++) begin
            at_neg();
            if (bus_do !== 8'hA5) bad_do++;
            if (bus_dv !== 1'b1) bad_dv++;
            if (bus_cs !== 1'b0) bad_cs++;
        end
        check_val("stall_dout_stable", 32'(bad_do), 32'd0);
        check_val("stall_valid_held", 32'(bad_dv), 32'd0);
        check_val("stall_cs_low", 32'(bad_cs), 32'd0);
        check_val("stall_sck_low", 32'(bus_sck), 32'd0);
        check_val("stall_sck_pulses", 32'(sck_pulses), 32'd48);
        at_pos();
        data_ready = 1'b1;
        wait_idle("stall", 2000);
        check_bytes("stall", '{8'hA5, 8'h5A, 8'h01, 8'hFE});

        // Zero-length request
        clear_mon();
        falls0 = cs_falls;
        issue(1'b0, 24'h000010, 16'd0);
        at_neg();
        check_val("len0_ready", 32'(rr0), 32'd1);
        check_val("len0_busy", 32'(busy0), 32'd0);
        repeat (10) at_neg();
        check_val("len0_cs_never_low", 32'(cs_falls), 32'(falls0));
        check_val("len0_no_data", 32'(got_q.size()), 32'd0);

        // Reset during the address phase, then a fresh one-byte read
        clear_mon();
        issue(1'b0, 24'h000010, 16'd4);
        n = 0;
        do begin
            at_neg();
            n++;
        end while (bit_cnt < 18 && n < 1000);
        check_val("abort_reached_addr", 32'(bit_cnt), 32'd18);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("abort_cs_n", 32'(cs0), 32'd1);
        check_val("abort_sck", 32'(sck0), 32'd0);
        repeat (3) at_pos();
        rst_n = 1'b1;
        at_neg();
        check_val("abort_no_valid", 32'(dv0), 32'd0);
        check_val("abort_no_bytes", 32'(got_q.size()), 32'd0);
        issue(1'b0, 24'h000000, 16'd1);
        wait_idle("after_abort", 1000);
        check_bytes("after_abort", '{8'h3C});

        // CLK_DIV=1, back-to-back requests with req_valid held high
        sel = 1'b1;
        repeat (2) at_pos();
        clear_mon();
        acc_cnt  = 0;
        req_addr = 24'h000011;
        req_len  = 16'd3;
        rv1      = 1'b1;
        n = 0;
        do begin
            at_neg();
            n++;
        end while (acc_cnt < 2 && n < 2000);
        at_pos();
        rv1 = 1'b0;
        check_val("b2b_accepts", 32'(acc_cnt), 32'd2);
        wait_idle("b2b", 1000);
        check_bytes("b2b", '{8'h5A, 8'h01, 8'hFE, 8'h5A, 8'h01, 8'hFE});
        check_val("b2b_gap_ok", 32'(acc_run[1] >= 2), 32'd1);
        check_val("b2b_valid_drained", 32'(acc_dv[1]), 32'd0);
        check_val("b2b_mosi_hdr", hdr, 32'h03000011);
        check_val("b2b_sck_high_min", 32'(hi_min), 32'd1);
        check_val("b2b_sck_high_max", 32'(hi_max), 32'd1);
        check_val("b2b_mosi_stable", 32'(mosi_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
